// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, addresses a combinational instruction memory and
// registers the returned word for decode, handling stalls, redirects, halt and address faults.
module fetch_controller #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        halt_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        instr_valid,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fault_addr,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {StIdle, StFetch, StHalt, StFault} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        valid_q, valid_d;
    logic [31:0] fault_addr_q, fault_addr_d;
    logic [31:0] count_q, count_d;

    // Misaligned or beyond the last word; also catches a PC that would wrap past 2^32.
    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(MEM_WORDS));
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            pc_q         <= RESET_PC;
            instr_q      <= 32'h0;
            pc_out_q     <= 32'h0;
            valid_q      <= 1'b0;
            fault_addr_q <= 32'h0;
            count_q      <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            pc_out_q     <= pc_out_d;
            valid_q      <= valid_d;
            fault_addr_q <= fault_addr_d;
            count_q      <= count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        pc_out_d     = pc_out_q;
        valid_d      = valid_q;
        fault_addr_d = fault_addr_q;
        count_d      = count_q;
        case (state_q)
            StIdle: begin
                state_d = StFetch;
            end
            StFetch: begin
                if (halt_req) begin
                    state_d = StHalt;
                    valid_d = 1'b0;
                end else if (addr_bad(pc_q)) begin
                    state_d      = StFault;
                    fault_addr_d = pc_q;
                    valid_d      = 1'b0;
                end else if (stall) begin
                    // Everything holds; a pending branch is re-presented once stall drops.
                end else if (branch_taken) begin
                    valid_d = 1'b0;
                    if (addr_bad(branch_target)) begin
                        state_d      = StFault;
                        fault_addr_d = branch_target;
                    end else begin
                        pc_d = branch_target;
                    end
                end else begin
                    instr_d  = imem_instr;
                    pc_out_d = pc_q;
                    valid_d  = 1'b1;
                    pc_d     = pc_q + 32'd4;
                    count_d  = count_q + 32'd1;
                end
            end
            StHalt: begin
                valid_d = 1'b0;
            end
            StFault: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign imem_addr   = pc_q;
    assign instr_out   = instr_q;
    assign pc_out      = pc_out_q;
    assign pc_plus4    = pc_out_q + 32'd4;
    assign instr_valid = valid_q;
    assign halted      = (state_q == StHalt);
    assign fault       = (state_q == StFault);
    assign fault_addr  = fault_addr_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller against a 256-word memory holding A000_0000 + index.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        halt_req = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        halted;
    logic        fault;
    logic [31:0] fault_addr;
    logic [31:0] fetch_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign imem_instr = 32'hA000_0000 + {24'h0, imem_addr[9:2]};

    fetch_controller #(
        .RESET_PC (32'h0000_0000),
        .MEM_WORDS(256)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .halt_req     (halt_req),
        .imem_addr    (imem_addr),
        .imem_instr   (imem_instr),
        .instr_out    (instr_out),
        .pc_out       (pc_out),
        .pc_plus4     (pc_plus4),
        .instr_valid  (instr_valid),
        .halted       (halted),
        .fault        (fault),
        .fault_addr   (fault_addr),
        .fetch_count  (fetch_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        step();
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_pc_out", pc_out, 32'h0);
        check("rst_instr", instr_out, 32'h0);
        check("rst_count", fetch_count, 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_fault_addr", fault_addr, 32'h0);
        check("rst_imem_addr", imem_addr, 32'h0);
        reset = 1'b0;

        // Sequential fetch: IDLE edge, then first capture
        step();
        check("idle_valid", 32'(instr_valid), 32'd0);
        step();
        check("f0_valid", 32'(instr_valid), 32'd1);
        check("f0_pc", pc_out, 32'h0);
        check("f0_instr", instr_out, 32'hA000_0000);
        check("f0_plus4", pc_plus4, 32'h4);
        step();
        check("f1_pc", pc_out, 32'h4);
        check("f1_instr", instr_out, 32'hA000_0001);
        step();
        check("f2_pc", pc_out, 32'h8);
        check("f2_instr", instr_out, 32'hA000_0002);

        // Stall three cycles at pc_out=8
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", pc_out, 32'h8);
            check("stall_instr", instr_out, 32'hA000_0002);
            check("stall_count", fetch_count, 32'd3);
            check("stall_valid", 32'(instr_valid), 32'd1);
        end
        stall = 1'b0;
        step();
        check("resume_pc", pc_out, 32'hC);
        check("resume_instr", instr_out, 32'hA000_0003);
        check("resume_count", fetch_count, 32'd4);

        // Branch to 0x40 while pc=0x10
        check("pre_branch_addr", imem_addr, 32'h10);
        branch_taken  = 1'b1;
        branch_target = 32'h40;
        step();
        branch_taken = 1'b0;
        check("bubble_valid", 32'(instr_valid), 32'd0);
        check("bubble_pc", pc_out, 32'hC);
        check("bubble_count", fetch_count, 32'd4);
        check("bubble_addr", imem_addr, 32'h40);
        step();
        check("tgt_valid", 32'(instr_valid), 32'd1);
        check("tgt_pc", pc_out, 32'h40);
        check("tgt_instr", instr_out, 32'hA000_0010);
        check("tgt_count", fetch_count, 32'd5);

        // Misaligned branch target faults
        branch_taken  = 1'b1;
        branch_target = 32'h42;
        step();
        branch_taken = 1'b0;
        check("bfault_fault", 32'(fault), 32'd1);
        check("bfault_addr", fault_addr, 32'h42);
        check("bfault_valid", 32'(instr_valid), 32'd0);
        step();
        step();
        check("bfault_hold", 32'(fault), 32'd1);
        check("bfault_addr_hold", fault_addr, 32'h42);
        check("bfault_halted", 32'(halted), 32'd0);

        // Reset out of FAULT
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rf_fault", 32'(fault), 32'd0);
        check("rf_fault_addr", fault_addr, 32'h0);
        check("rf_count", fetch_count, 32'd0);
        check("rf_valid", 32'(instr_valid), 32'd0);
        step();
        check("rf_idle_valid", 32'(instr_valid), 32'd0);
        step();
        check("rf_first_valid", 32'(instr_valid), 32'd1);
        check("rf_first_pc", pc_out, 32'h0);

        // Halt with branch and stall also high: halt wins, pc unchanged
        halt_req      = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h80;
        stall         = 1'b1;
        step();
        halt_req     = 1'b0;
        branch_taken = 1'b0;
        stall        = 1'b0;
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_valid", 32'(instr_valid), 32'd0);
        check("halt_addr", imem_addr, 32'h4);
        for (int i = 0; i < 4; i++) step();
        check("halt_hold", 32'(halted), 32'd1);
        check("halt_hold_addr", imem_addr, 32'h4);
        check("halt_hold_count", fetch_count, 32'd1);
        check("halt_hold_valid", 32'(instr_valid), 32'd0);

        // Reset out of HALT
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rh_halted", 32'(halted), 32'd0);
        check("rh_pc", pc_out, 32'h0);
        check("rh_instr", instr_out, 32'h0);
        step();
        step();
        check("rh_first_valid", 32'(instr_valid), 32'd1);
        check("rh_first_pc", pc_out, 32'h0);

        // Run off the end of memory
        branch_taken  = 1'b1;
        branch_target = 32'h3F8;
        step();
        branch_taken = 1'b0;
        step();
        check("end0_pc", pc_out, 32'h3F8);
        check("end0_instr", instr_out, 32'hA000_00FE);
        step();
        check("end1_pc", pc_out, 32'h3FC);
        check("end1_instr", instr_out, 32'hA000_00FF);
        check("end1_valid", 32'(instr_valid), 32'd1);
        step();
        check("oor_fault", 32'(fault), 32'd1);
        check("oor_fault_addr", fault_addr, 32'h400);
        check("oor_pc", pc_out, 32'h3FC);
        check("oor_valid", 32'(instr_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequences the word-addressed, combinationally-read instruction memory (256 words, byte address shifted right by 2). Owns the program counter, drives the memory address each cycle, registers the returned instruction with a valid flag for the decode stage, and handles stalls, branch redirects, halt requests and address faults. Sits between the instruction memory and the decode/control logic of the processor.

## Interface
- RESET_PC, 32'h00000000, byte address loaded into PC on reset; must be word-aligned
- MEM_WORDS, 256, instruction memory depth in words; valid PCs are 0 .. 4*MEM_WORDS-4

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset; one clock, sampled on rising edge of clk
- stall  in  1  hold PC and output registers this cycle
- branch_taken  in  1  redirect PC to branch_target this cycle
- branch_target  in  32  byte address of redirect
- halt_req  in  1  stop fetching permanently (until reset)
- imem_addr  out  32  byte address to instruction memory
- imem_instr  in  32  instruction returned combinationally for imem_addr
- instr_out  out  32  registered instruction
- pc_out  out  32  registered byte address of instr_out
- pc_plus4  out  32  pc_out + 4, combinational
- instr_valid  out  1  instr_out/pc_out hold a fetched instruction
- halted  out  1  controller in HALT
- fault  out  1  controller in FAULT
- fault_addr  out  32  offending address latched on fault entry
- fetch_count  out  32  number of cycles instr_valid was newly asserted with a fresh instruction

## Operation
- States: IDLE, FETCH, HALT, FAULT. Internal register pc (32 bit).
- Reset: state=IDLE, pc=RESET_PC, instr_out=0, pc_out=0, instr_valid=0, halted=0, fault=0, fault_addr=0, fetch_count=0.
- imem_addr = pc at all times (combinational).
- IDLE: next cycle -> FETCH unconditionally; no capture.
- FETCH, per cycle, priority highest first:
  - halt_req=1 -> HALT; instr_valid<=0; pc holds.
  - pc[1:0]!=0 or (pc>>2)>=MEM_WORDS -> FAULT; fault_addr<=pc; instr_valid<=0.
  - stall=1 -> pc, instr_out, pc_out, instr_valid, fetch_count all hold; branch_taken ignored (requester holds it until stall drops).
  - branch_taken=1 -> if branch_target[1:0]!=0 or (branch_target>>2)>=MEM_WORDS: FAULT, fault_addr<=branch_target, instr_valid<=0; else pc<=branch_target, instr_valid<=0 (instruction at old pc flushed), instr_out/pc_out hold.
  - otherwise -> instr_out<=imem_instr, pc_out<=pc, instr_valid<=1, pc<=pc+4, fetch_count<=fetch_count+1.
- HALT: halted=1, instr_valid=0, all registers hold; exit only via reset.
- FAULT: fault=1, instr_valid=0, fault_addr holds; exit only via reset.
- pc+4 and fetch_count are modulo 2^32; pc overflow is caught as out-of-range before it can wrap.
- pc_plus4 = pc_out + 4, valid whenever instr_valid=1.

## Timing
- Fetch latency: 1 cycle — instruction at pc appears on instr_out the edge after pc is presented.
- First valid instruction: reset deasserted at edge 0 -> IDLE; FETCH at edge 1; instr_valid=1 after edge 2 with pc_out=RESET_PC.
- Sustained throughput: one instruction per cycle with stall=0, branch_taken=0.
- Branch: one bubble; instruction at branch_target valid two edges after branch_taken sampled.
- halted/fault assert the edge after the triggering condition is sampled.
- Reset mid-operation (any state) takes effect on the next edge and overrides all other inputs.
- halt_req and branch_taken in the same cycle: halt wins, branch dropped.
- halt_req during stall: halt wins.

## Test plan
- Sequential fetch: memory word i = 32'hA000_0000+i, reset then run 5 cycles -> pc_out 0,4,8,12 with instr_out A0000000..A0000003, fetch_count=4.
- Stall: assert stall 3 cycles at pc_out=8 -> instr_out/pc_out/fetch_count frozen, resume with pc_out=12 next.
- Branch: branch_taken with target 0x40 while pc=0x10 -> one cycle instr_valid=0, then pc_out=0x40, instr_out=A0000010.
- Faults: branch_target=0x42 -> fault=1, fault_addr=0x42; separately run sequentially past 0x3FC -> fault=1, fault_addr=0x400, last valid pc_out=0x3FC.
- Halt priority: halt_req with branch_taken and stall all high -> halted=1, instr_valid=0, pc unchanged; held indefinitely.
- Reset mid-run from HALT and FAULT -> all outputs return to reset values, first valid pc_out=RESET_PC two edges later.
